// File: rtl/fuzzy_aggregator_stream.sv
// Streaming fuzzy rule aggregator: accumulates S_w and S_wg over a frame of NUM_RULES beats.
// Optional sticky overflow flag with synchronous clear under FUZZY_AGG_STICKY_OVF_EN.
module fuzzy_aggregator_stream #(
    parameter int unsigned NUM_RULES = 9,
    parameter int unsigned W_W       = 16,
    parameter int unsigned G_W       = 8,
    parameter int unsigned ACC_W     = W_W + $clog2(NUM_RULES) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RULES-1:0] rule_mask,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_W-1:0]       in_w,
    input  logic [G_W-1:0]       in_g,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_W-1:0]       S_w,
    output logic [W_W-1:0]       S_wg,
    output logic                 sat_w,
    output logic                 sat_wg,
`ifdef FUZZY_AGG_STICKY_OVF_EN
    output logic                 ovf_sticky,
    input  logic                 ovf_clr,
`endif
    output logic                 frame_err
);

    localparam int unsigned CNT_W   = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
    localparam int unsigned GQ_W    = 16;
    localparam int unsigned PROD_W  = W_W + GQ_W + 1;
    localparam int unsigned FLUSH_W = 2;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(NUM_RULES - 1);
    localparam logic [ACC_W-1:0]   SAT_MAX  = ACC_W'((64'd1 << (W_W - 1)) - 64'd1);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(2);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [NUM_RULES-1:0] mask_q, mask_d;
    logic [W_W-1:0]       s1_w_q, s1_w_d;
    logic [GQ_W-1:0]      s1_g_q, s1_g_d;
    logic [W_W-1:0]       p_w_q, p_w_d;
    logic [W_W:0]         prod_q, prod_d;
    logic [ACC_W-1:0]     acc_w_q, acc_w_d;
    logic [ACC_W-1:0]     acc_wg_q, acc_wg_d;
    logic [W_W-1:0]       s_w_q, s_w_d;
    logic [W_W-1:0]       s_wg_q, s_wg_d;
    logic                 sat_w_q, sat_w_d;
    logic                 sat_wg_q, sat_wg_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 frame_err_q, frame_err_d;
`ifdef FUZZY_AGG_STICKY_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    logic                 accept_c;
    logic                 last_beat_c;
    logic                 rule_en_c;
    logic [NUM_RULES-1:0] cur_mask_c;
    logic [31:0]          g_cl_c;
    logic [GQ_W-1:0]      g_q15_c;
    logic                 load_c;

    // Percent to Q1.15 with rounding; inputs above 100 clamp to 100 (= 32767).
    always_comb begin
        g_cl_c  = (32'(in_g) > 32'd100) ? 32'd100 : 32'(in_g);
        g_q15_c = GQ_W'((g_cl_c * 32'd32767 + 32'd50) / 32'd100);
    end

    assign accept_c    = in_valid && in_ready_q;
    assign last_beat_c = (cnt_q == LAST_CNT);
    assign cur_mask_c  = (cnt_q == '0) ? rule_mask : mask_q;
    assign rule_en_c   = cur_mask_c[cnt_q];
    assign load_c      = (state_q == ST_FLUSH) && (flush_q == FLUSH_END);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        mask_d      = mask_q;
        s1_w_d      = '0;
        s1_g_d      = '0;
        p_w_d       = s1_w_q;
        prod_d      = (W_W + 1)'((PROD_W'(s1_w_q) * PROD_W'(s1_g_q) + PROD_W'(1 << 14)) >> 15);
        acc_w_d     = acc_w_q + ACC_W'(p_w_q);
        acc_wg_d    = acc_wg_q + ACC_W'(prod_q);
        s_w_d       = s_w_q;
        s_wg_d      = s_wg_q;
        sat_w_d     = sat_w_q;
        sat_wg_d    = sat_wg_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_ACC: begin
                if (accept_c) begin
                    if (rule_en_c) begin
                        s1_w_d = in_w;
                        s1_g_d = g_q15_c;
                    end
                    if (in_last != last_beat_c) begin
                        // Misaligned frame: drop everything already in flight.
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        s1_w_d      = '0;
                        s1_g_d      = '0;
                        p_w_d       = '0;
                        prod_d      = '0;
                        acc_w_d     = '0;
                        acc_wg_d    = '0;
                    end else if (last_beat_c) begin
                        cnt_d   = '0;
                        flush_d = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        if (cnt_q == '0) begin
                            mask_d = rule_mask;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = flush_q + FLUSH_W'(1);
                if (load_c) begin
                    sat_w_d     = (acc_w_q > SAT_MAX);
                    sat_wg_d    = (acc_wg_q > SAT_MAX);
                    s_w_d       = sat_w_d ? W_W'(SAT_MAX) : W_W'(acc_w_q);
                    s_wg_d      = sat_wg_d ? W_W'(SAT_MAX) : W_W'(acc_wg_q);
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    acc_w_d     = '0;
                    acc_wg_d    = '0;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        in_ready_d = (state_d == ST_ACC);
    end

`ifdef FUZZY_AGG_STICKY_OVF_EN
    // Clear has priority over a same-cycle saturation.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (load_c && (sat_w_d || sat_wg_d)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            flush_q     <= '0;
            mask_q      <= '0;
            s1_w_q      <= '0;
            s1_g_q      <= '0;
            p_w_q       <= '0;
            prod_q      <= '0;
            acc_w_q     <= '0;
            acc_wg_q    <= '0;
            s_w_q       <= '0;
            s_wg_q      <= '0;
            sat_w_q     <= 1'b0;
            sat_wg_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            mask_q      <= mask_d;
            s1_w_q      <= s1_w_d;
            s1_g_q      <= s1_g_d;
            p_w_q       <= p_w_d;
            prod_q      <= prod_d;
            acc_w_q     <= acc_w_d;
            acc_wg_q    <= acc_wg_d;
            s_w_q       <= s_w_d;
            s_wg_q      <= s_wg_d;
            sat_w_q     <= sat_w_d;
            sat_wg_q    <= sat_wg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign S_w       = s_w_q;
    assign S_wg      = s_wg_q;
    assign sat_w     = sat_w_q;
    assign sat_wg    = sat_wg_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fuzzy_aggregator_stream.sv
// Self-checking bench for fuzzy_aggregator_stream: vector table, random frames with a
// reference model, and hand sequences for back-pressure, frame errors and mid-frame reset.
module tb_fuzzy_aggregator_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  rule_mask = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_w = '0;
    logic [7:0]  in_g = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] S_w;
    logic [15:0] S_wg;
    logic        sat_w;
    logic        sat_wg;
    logic        frame_err;
`ifdef FUZZY_AGG_STICKY_OVF_EN
    logic        ovf_sticky;
    logic        ovf_clr = 1'b0;
`endif

    fuzzy_aggregator_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rule_mask (rule_mask),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_g      (in_g),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S_w       (S_w),
        .S_wg      (S_wg),
        .sat_w     (sat_w),
        .sat_wg    (sat_wg),
`ifdef FUZZY_AGG_STICKY_OVF_EN
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sw;
        logic [15:0] swg;
        logic        satw;
        logic        satwg;
    } res_t;

    typedef struct {
        logic [8:0]  mask;
        logic [15:0] w0;
        logic [7:0]  g0;
        logic [15:0] w;
        logic [7:0]  g;
        res_t        exp;
    } vec_t;

    res_t        sb[$];
    vec_t        vt[6];
    logic [15:0] bw[9];
    logic [7:0]  bg[9];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent per-frame reference computation.
    function automatic res_t model(input logic [8:0] mask);
        longint sw = 0;
        longint swg = 0;
        longint gq;
        longint gg;
        res_t r;
        for (int i = 0; i < 9; i++) begin
            if (mask[i]) begin
                gg = (bg[i] > 8'd100) ? 100 : longint'(bg[i]);
                gq = (gg * 32767 + 50) / 100;
                if (gq > 32767) gq = 32767;
                sw  += longint'(bw[i]);
                swg += (longint'(bw[i]) * gq + 16384) >>> 15;
            end
        end
        r.satw  = (sw > 32767);
        r.satwg = (swg > 32767);
        r.sw    = r.satw ? 16'd32767 : 16'(sw);
        r.swg   = r.satwg ? 16'd32767 : 16'(swg);
        return r;
    endfunction

    // Output monitor: every result handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("S_w", 32'(S_w), 32'(e.sw));
                chk("S_wg", 32'(S_wg), 32'(e.swg));
                chk("sat_w", 32'(sat_w), 32'(e.satw));
                chk("sat_wg", 32'(sat_wg), 32'(e.satwg));
            end
        end
    end

    task automatic send_frame(input logic [8:0] mask, input int nb, input int last_at,
                              input bit chk_lat);
        int n;
        int k;
        rule_mask = mask;
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_w     = bw[i];
            in_g     = bg[i];
            in_last  = (i == last_at);
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (chk_lat) begin
            k = 0;
            while (!out_valid && k < 10) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("latency", 32'(k), 32'd3);
        end
    endtask

    task automatic fill(input logic [15:0] w0, input logic [7:0] g0,
                        input logic [15:0] w, input logic [7:0] g);
        for (int i = 0; i < 9; i++) begin
            bw[i] = (i == 0) ? w0 : w;
            bg[i] = (i == 0) ? g0 : g;
        end
    endtask

    initial begin
        int   ov;
        res_t e;

        vt[0] = '{9'h1FF, 16'h0800, 8'd50,  16'h0800, 8'd50,  '{16'd18432, 16'd9216,  1'b0, 1'b0}};
        vt[1] = '{9'h145, 16'h0800, 8'd50,  16'h0800, 8'd50,  '{16'd8192,  16'd4096,  1'b0, 1'b0}};
        vt[2] = '{9'h001, 16'h7FFF, 8'd100, 16'h0000, 8'd0,   '{16'd32767, 16'd32766, 1'b0, 1'b0}};
        vt[3] = '{9'h001, 16'h7FFF, 8'd200, 16'h0000, 8'd0,   '{16'd32767, 16'd32766, 1'b0, 1'b0}};
        vt[4] = '{9'h1FF, 16'h4000, 8'd100, 16'h4000, 8'd100, '{16'd32767, 16'd32767, 1'b1, 1'b1}};
        vt[5] = '{9'h000, 16'h1234, 8'd77,  16'h1234, 8'd77,  '{16'd0,     16'd0,     1'b0, 1'b0}};

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S_w", 32'(S_w), 32'd0);
        chk("rst_S_wg", 32'(S_wg), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            fill(vt[t].w0, vt[t].g0, vt[t].w, vt[t].g);
            sb.push_back(vt[t].exp);
            send_frame(vt[t].mask, 9, 8, 1'b1);
        end

        for (int r = 0; r < 3; r++) begin
            logic [8:0] m;
            m = 9'($urandom);
            for (int i = 0; i < 9; i++) begin
                bw[i] = 16'($urandom_range(0, 16'hFFFF));
                bg[i] = 8'($urandom_range(0, 255));
            end
            sb.push_back(model(m));
            send_frame(m, 9, 8, 1'b1);
        end

        // Back-pressure: result must hold for 5 cycles, then release.
        while (out_valid) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        fill(vt[0].w0, vt[0].g0, vt[0].w, vt[0].g);
        sb.push_back(vt[0].exp);
        send_frame(vt[0].mask, 9, 8, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_S_w", 32'(S_w), 32'd18432);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        fill(vt[1].w0, vt[1].g0, vt[1].w, vt[1].g);
        sb.push_back(vt[1].exp);
        send_frame(vt[1].mask, 9, 8, 1'b1);

        // Early in_last on beat 4.
        while (out_valid) begin
            @(posedge clk);
            #1;
        end
        fill(16'h0800, 8'd50, 16'h0800, 8'd50);
        send_frame(9'h1FF, 5, 4, 1'b0);
        chk("early_last_err", 32'(frame_err), 32'd1);
        @(posedge clk);
        #1;
        chk("err_one_cycle", 32'(frame_err), 32'd0);
        ov = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            ov = ov | int'(out_valid);
        end
        chk("err_no_valid", 32'(ov), 32'd0);

        // Missing in_last on beat 8.
        send_frame(9'h1FF, 9, -1, 1'b0);
        chk("missing_last_err", 32'(frame_err), 32'd1);
        ov = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            ov = ov | int'(out_valid);
        end
        chk("err2_no_valid", 32'(ov), 32'd0);
        sb.push_back(vt[1].exp);
        fill(vt[1].w0, vt[1].g0, vt[1].w, vt[1].g);
        send_frame(vt[1].mask, 9, 8, 1'b1);

        // Reset mid-frame.
        while (out_valid) begin
            @(posedge clk);
            #1;
        end
        fill(16'h4000, 8'd100, 16'h4000, 8'd100);
        send_frame(9'h1FF, 4, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_S_w", 32'(S_w), 32'd0);
        chk("mid_rst_sat", 32'({sat_w, sat_wg}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill(vt[0].w0, vt[0].g0, vt[0].w, vt[0].g);
        sb.push_back(vt[0].exp);
        send_frame(vt[0].mask, 9, 8, 1'b1);

        for (int c = 0; c < 50 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        e = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
